// File: rtl/knn_pkg.sv
// Shared definitions for the host-to-KNN-core register pipeline.
package knn_pkg;

  localparam int unsigned CMD_WIDTH = 4;
  localparam int unsigned CMD_WR    = 0;
  localparam int unsigned CMD_RD    = 1;
  localparam int unsigned CMD_START = 2;
  localparam int unsigned CMD_DONE  = 3;

  typedef logic [CMD_WIDTH-1:0] cmd_t;

  // Layout of one beat; the widths are set by the pipeline's parameters.
  typedef enum logic [1:0] {
    BEAT_CMD  = 2'd0,
    BEAT_K    = 2'd1,
    BEAT_DATA = 2'd2
  } beat_field_e;

  // A simultaneous write and read is ambiguous; the write wins.
  function automatic logic is_conflict(input cmd_t cmd);
    return cmd[CMD_WR] & cmd[CMD_RD];
  endfunction

  function automatic cmd_t resolve_cmd(input cmd_t cmd);
    cmd_t res;
    res = cmd;
    if (is_conflict(cmd)) res[CMD_RD] = 1'b0;
    return res;
  endfunction

endpackage

// File: rtl/knn_pipe_slot.sv
// One elastic pipeline slot: a valid bit plus a payload register.
module knn_pipe_slot #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // Load beats clear, so a slot that hands off and refills in one cycle stays valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      if (flush)      valid <= 1'b0;
      else if (load)  valid <= 1'b1;
      else if (clr)   valid <= 1'b0;
      if (load && !flush) q <= d;
    end
  end

endmodule

// File: rtl/knn_reg_pipe.sv
// Elastic valid/ready register pipeline carrying command, k and masked
// channel data from the host register interface to the KNN core.
module knn_reg_pipe
  import knn_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned NUM_CH     = 1,
  parameter  int unsigned K_WIDTH    = 32,
  parameter  int unsigned STAGES     = 2,
  localparam int unsigned OCC_W      = $clog2(STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [CMD_WIDTH-1:0]         s_cmd,
  input  logic [K_WIDTH-1:0]           s_k,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_CH-1:0]            s_ch_mask,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [CMD_WIDTH-1:0]         m_cmd,
  output logic [K_WIDTH-1:0]           m_k,
  output logic [NUM_CH*DATA_WIDTH-1:0] m_data,
  output logic [OCC_W-1:0]             occupancy,
  output logic                         cmd_err
);

  localparam int unsigned DW_ALL = NUM_CH * DATA_WIDTH;
  localparam int unsigned BEAT_W = CMD_WIDTH + K_WIDTH + DW_ALL;

  typedef struct packed {
    logic [CMD_WIDTH-1:0] cmd;
    logic [K_WIDTH-1:0]   k;
    logic [DW_ALL-1:0]    data;
  } beat_t;

  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] nxt_valid;
  logic [BEAT_W-1:0] slot_q [STAGES];
  logic [OCC_W-1:0]  nxt_occ;
  beat_t             in_beat;
  beat_t             out_beat;
  logic              alive;
  logic              accept;

  // Ready ripples back from the core so bubbles collapse.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = valid[STAGES-1] & m_ready;
    for (int i = int'(STAGES) - 2; i >= 0; i--) begin
      adv[i] = valid[i] & (~valid[i+1] | adv[i+1]);
    end
  end

  assign s_ready = alive & ~flush & (~valid[0] | adv[0]);
  assign accept  = s_valid & s_ready;

  always_comb begin
    load    = '0;
    load[0] = accept;
    for (int i = 1; i < int'(STAGES); i++) begin
      load[i] = adv[i-1] & ~flush;
    end
    nxt_valid = '0;
    nxt_occ   = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      nxt_valid[i] = ~flush & (load[i] | (valid[i] & ~adv[i]));
      nxt_occ      = nxt_occ + OCC_W'(nxt_valid[i]);
    end
  end

  // Masked channels are zeroed on entry; the mask itself is not carried.
  always_comb begin
    in_beat.cmd  = resolve_cmd(s_cmd);
    in_beat.k    = s_k;
    in_beat.data = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (s_ch_mask[c]) in_beat.data[c*DATA_WIDTH +: DATA_WIDTH] = s_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  for (genvar i = 0; i < int'(STAGES); i++) begin : g_slot
    logic [BEAT_W-1:0] d;
    if (i == 0) begin : g_head
      assign d = in_beat;
    end else begin : g_body
      assign d = slot_q[i-1];
    end
    knn_pipe_slot #(.W(BEAT_W)) u_slot (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .load  (load[i]),
      .clr   (adv[i]),
      .d     (d),
      .valid (valid[i]),
      .q     (slot_q[i])
    );
  end

  assign out_beat = beat_t'(slot_q[STAGES-1]);
  assign m_valid  = valid[STAGES-1];
  assign m_cmd    = out_beat.cmd;
  assign m_k      = out_beat.k;
  assign m_data   = out_beat.data;

  // alive keeps s_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alive     <= 1'b0;
      occupancy <= '0;
      cmd_err   <= 1'b0;
    end else begin
      alive     <= 1'b1;
      occupancy <= nxt_occ;
      if (flush)                                cmd_err <= 1'b0;
      else if (accept && is_conflict(s_cmd))    cmd_err <= 1'b1;
    end
  end

endmodule

// File: doc/knn_reg_pipe.md
Name: knn_reg_pipe

Overview:
Parametrised elastic register pipeline between the host-side register interface and the KNN core (knnTop). It replaces the fixed single-stage control/data register slice with STAGES valid/ready stages. It carries NUM_CH data channels plus command bits and k, supports backpressure, per-channel masking, flush and command-conflict detection. Throughput is one beat per cycle; latency is STAGES cycles.

Parameters:
DATA_WIDTH, 32, width of one data channel
NUM_CH, 1, number of data channels (>=1)
K_WIDTH, 32, width of k
STAGES, 2, number of pipeline slots (>=1)
OCC_W, $clog2(STAGES+1), occupancy count width (derived, not overridden)

Ports:
clk  in  1  single clock, all logic rising-edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of all slots and the error flag
s_valid  in  1  upstream beat valid
s_ready  out  1  pipeline can accept a beat
s_cmd  in  4  {done,start,rd_en,wr_en}, bit indices from package
s_k  in  K_WIDTH  k value for this beat
s_data  in  NUM_CH*DATA_WIDTH  channel data, ch0 in LSBs
s_ch_mask  in  NUM_CH  1 = channel passes, 0 = channel zeroed
m_valid  out  1  beat valid toward core
m_ready  in  1  core accepts beat
m_cmd  out  4  command bits
m_k  out  K_WIDTH  k
m_data  out  NUM_CH*DATA_WIDTH  masked channel data
occupancy  out  OCC_W  number of valid slots
cmd_err  out  1  sticky: a wr_en+rd_en conflict was seen

Behaviour:
- Reset (reset=0, async): all slot valid bits 0, all payload registers 0. m_valid=0, m_cmd=0, m_k=0, m_data=0, occupancy=0, cmd_err=0. s_ready is 0 while reset is asserted and 1 from the first cycle after release.
- Slot i (0..STAGES-1) holds valid[i] and a payload. Slot STAGES-1 drives the m_* outputs directly from registers; there is no combinational path from s_* to m_*.
- Advance rule: adv[STAGES-1] = valid[STAGES-1] & m_ready. For i<STAGES-1, adv[i] = valid[i] & (~valid[i+1] | adv[i+1]). Slot i+1 loads slot i when adv[i]. Slot i clears when it advances and is not reloaded.
- s_ready = ~valid[0] | adv[0]. Accept = s_valid & s_ready & ~flush. Slot 0 loads on accept.
- Ready propagates combinationally through the chain. Bubbles collapse, so full throughput holds with m_ready held high.
- Latency: a beat accepted in cycle t appears on m_valid in cycle t+STAGES when no stall occurs.
- Stability: while m_valid=1 and m_ready=0, m_cmd, m_k and m_data hold constant. m_valid never deasserts without a handshake, except on flush or reset.
- Masking is applied at slot-0 load: channel c data is zeroed when s_ch_mask[c]=0. The mask is not stored.
- Command conflict: if an accepted beat has wr_en=1 and rd_en=1, rd_en is cleared in the stored beat (write wins) and cmd_err is set. cmd_err is sticky and cleared only by flush or reset.
- Flush (flush=1 in cycle t): from cycle t+1 all valid bits are 0, occupancy=0 and cmd_err=0. Payload registers keep their values but are masked by m_valid=0. s_ready=0 during cycle t, no beat is accepted in cycle t, and m_ready in cycle t has no effect.
- Flush has priority over accept and advance. Reset has priority over everything.
- occupancy is registered and equals the popcount of valid[] after each edge. Range is 0..STAGES.
- Full: all slots valid and m_ready=0 gives s_ready=0. Full with m_ready=1 gives s_ready=1, and in/out occur in the same cycle with occupancy unchanged.
- Empty: m_valid=0. A new beat passes through with latency STAGES.
- Reset mid-stream: in-flight beats are discarded, with no partial output.

Decomposition:
- Shared package knn_pkg holds: CMD_WIDTH=4, CMD_WR=0, CMD_RD=1, CMD_START=2, CMD_DONE=3, and a beat struct/typedef {cmd, k, data}.
- One natural sub-module, knn_pipe_slot: a single valid+payload register with load/clear inputs. It is instantiated STAGES times with a generate loop.
- knn_reg_pipe contains the advance chain, mask, conflict logic, occupancy and cmd_err.

Test Plan:
- Reset, then STAGES=2 and m_ready=1: send beats k=1,2,3 on consecutive cycles -> m_valid high from the 2nd cycle after the first accept, outputs k=1,2,3 in order with no gaps, occupancy peaks at 2.
- Backpressure: hold m_ready=0 and push 3 beats with STAGES=2 -> only 2 accepted, s_ready=0, occupancy=2, m_k frozen at the first beat; raise m_ready -> 3rd beat accepted in the same cycle as the first handshake.
- NUM_CH=4, s_data=0x44443333_22221111_...(4 channels), s_ch_mask=4'b0101 -> m_data has channels 1 and 3 zero, channels 0 and 2 unchanged.
- Beat with s_cmd=4'b0011 -> m_cmd=4'b0001 and cmd_err=1 persists across later clean beats; flush -> cmd_err=0 and occupancy=0 next cycle.
- Flush with s_valid=1 and 2 beats in flight -> that beat is not accepted, m_valid=0 the next cycle, and no stale beat appears later.
- Assert reset asynchronously mid-clock with the pipe full -> all outputs 0 immediately; after release, s_ready=1 and the next beat has latency STAGES.
